// File: rtl/sa_pe_mac_if.sv
// rtl/sa_pe_mac_if.sv - operand, result and status bundle of the systolic-array MAC PE
// Optional SA_PE_SAT_EN adds the o_sat result flag.
interface sa_pe_mac_if #(
  parameter int DAT_WIDTH = 16,
  parameter int ACC_WIDTH = 40,
  parameter int CNT_WIDTH = 16
);
  logic [CNT_WIDTH-1:0] i_k_len;
  logic                 i_a_vld;
  logic [DAT_WIDTH-1:0] i_a;
  logic                 i_b_vld;
  logic [DAT_WIDTH-1:0] i_b;
  logic                 o_a_vld;
  logic [DAT_WIDTH-1:0] o_a;
  logic                 o_b_vld;
  logic [DAT_WIDTH-1:0] o_b;
  logic                 o_res_vld;
  logic [ACC_WIDTH-1:0] o_res;
  logic                 i_res_rdy;
  logic                 o_busy;
  logic                 o_ovf;
  logic                 o_err;
`ifdef SA_PE_SAT_EN
  logic                 o_sat;
`endif

  modport master (
    output i_k_len, i_a_vld, i_a, i_b_vld, i_b, i_res_rdy,
`ifdef SA_PE_SAT_EN
    input  o_sat,
`endif
    input  o_a_vld, o_a, o_b_vld, o_b, o_res_vld, o_res, o_busy, o_ovf, o_err
  );

  modport slave (
    input  i_k_len, i_a_vld, i_a, i_b_vld, i_b, i_res_rdy,
`ifdef SA_PE_SAT_EN
    output o_sat,
`endif
    output o_a_vld, o_a, o_b_vld, o_b, o_res_vld, o_res, o_busy, o_ovf, o_err
  );
endinterface

// File: rtl/sa_pe_mac.sv
// rtl/sa_pe_mac.sv - output-stationary MAC PE: forwards operands, accumulates K_LEN products per tile
// Optional SA_PE_SAT_EN: saturating accumulation with a per-result o_sat flag.
module sa_pe_mac #(
  parameter int DAT_WIDTH = 16,
  parameter int ACC_WIDTH = 40,
  parameter int CNT_WIDTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  sa_pe_mac_if.slave bus
);
  typedef enum logic {IDLE, ACC} state_t;

  state_t                      state_q, state_d;
  logic                        a_vld_q, a_vld_d, b_vld_q, b_vld_d;
  logic [DAT_WIDTH-1:0]        a_q, a_d, b_q, b_d;
  logic signed [ACC_WIDTH-1:0] acc_q, acc_d, res_q, res_d;
  logic [CNT_WIDTH-1:0]        cnt_q, cnt_d, k_q, k_d;
  logic                        res_vld_q, res_vld_d, ovf_q, ovf_d, err_q, err_d;
  logic                        fire, done;
  logic [CNT_WIDTH-1:0]        k_eff, cnt_inc;
  logic signed [2*DAT_WIDTH-1:0] prod;
  logic signed [ACC_WIDTH-1:0] prod_ext, base, sum;
`ifdef SA_PE_SAT_EN
  logic                        tile_sat_q, tile_sat_d, res_sat_q, res_sat_d, clip;
  logic signed [ACC_WIDTH-1:0] raw;
`endif

  always_comb begin
    fire     = bus.i_a_vld & bus.i_b_vld;
    prod     = $signed(bus.i_a) * $signed(bus.i_b);
    prod_ext = ACC_WIDTH'(prod);
    k_eff    = (bus.i_k_len == '0) ? CNT_WIDTH'(1) : bus.i_k_len;
    cnt_inc  = cnt_q + CNT_WIDTH'(1);
    // A tile always starts from zero, so the first product needs no stale accumulator.
    base     = (state_q == ACC) ? acc_q : '0;
`ifdef SA_PE_SAT_EN
    raw  = base + prod_ext;
    clip = (base[ACC_WIDTH-1] == prod_ext[ACC_WIDTH-1]) &&
           (raw[ACC_WIDTH-1] != base[ACC_WIDTH-1]);
    if (clip) begin
      sum = base[ACC_WIDTH-1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}} : {1'b0, {(ACC_WIDTH-1){1'b1}}};
    end else begin
      sum = raw;
    end
`else
    sum = base + prod_ext;
`endif
    done = fire & ((state_q == IDLE) ? (k_eff == CNT_WIDTH'(1)) : (cnt_inc == k_q));

    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    k_d       = k_q;
    res_d     = res_q;
    res_vld_d = res_vld_q;
    ovf_d     = ovf_q;
    err_d     = err_q | (bus.i_a_vld ^ bus.i_b_vld);
    a_vld_d   = bus.i_a_vld;
    a_d       = bus.i_a;
    b_vld_d   = bus.i_b_vld;
    b_d       = bus.i_b;
`ifdef SA_PE_SAT_EN
    tile_sat_d = tile_sat_q;
    res_sat_d  = res_sat_q;
`endif

    if (fire) begin
      acc_d = sum;
      if (state_q == IDLE) begin
        k_d   = k_eff;
        cnt_d = CNT_WIDTH'(1);
      end else begin
        cnt_d = cnt_inc;
      end
      state_d = done ? IDLE : ACC;
`ifdef SA_PE_SAT_EN
      tile_sat_d = ((state_q == ACC) & tile_sat_q) | clip;
`endif
    end

    // A new completion always wins the result register; losing an unread result is flagged.
    if (done) begin
      res_d     = sum;
      res_vld_d = 1'b1;
      if (res_vld_q & ~bus.i_res_rdy) ovf_d = 1'b1;
`ifdef SA_PE_SAT_EN
      res_sat_d = tile_sat_d;
`endif
    end else if (res_vld_q & bus.i_res_rdy) begin
      res_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      k_q       <= '0;
      res_q     <= '0;
      res_vld_q <= 1'b0;
      ovf_q     <= 1'b0;
      err_q     <= 1'b0;
      a_vld_q   <= 1'b0;
      a_q       <= '0;
      b_vld_q   <= 1'b0;
      b_q       <= '0;
`ifdef SA_PE_SAT_EN
      tile_sat_q <= 1'b0;
      res_sat_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      k_q       <= k_d;
      res_q     <= res_d;
      res_vld_q <= res_vld_d;
      ovf_q     <= ovf_d;
      err_q     <= err_d;
      a_vld_q   <= a_vld_d;
      a_q       <= a_d;
      b_vld_q   <= b_vld_d;
      b_q       <= b_d;
`ifdef SA_PE_SAT_EN
      tile_sat_q <= tile_sat_d;
      res_sat_q  <= res_sat_d;
`endif
    end
  end

  assign bus.o_a_vld   = a_vld_q;
  assign bus.o_a       = a_q;
  assign bus.o_b_vld   = b_vld_q;
  assign bus.o_b       = b_q;
  assign bus.o_res_vld = res_vld_q;
  assign bus.o_res     = res_q;
  assign bus.o_busy    = (state_q == ACC);
  assign bus.o_ovf     = ovf_q;
  assign bus.o_err     = err_q;
`ifdef SA_PE_SAT_EN
  assign bus.o_sat     = res_sat_q;
`endif
endmodule

// File: tb/tb_sa_pe_mac.sv
// tb/tb_sa_pe_mac.sv - scoreboard bench for sa_pe_mac (DAT_WIDTH=16, ACC_WIDTH=32)
module tb_sa_pe_mac;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    logic signed [31:0] res;
    logic               sat;
  } exp_t;
  exp_t exp_q[$];

  sa_pe_mac_if #(.DAT_WIDTH(16), .ACC_WIDTH(32), .CNT_WIDTH(16)) bus ();

  sa_pe_mac #(.DAT_WIDTH(16), .ACC_WIDTH(32), .CNT_WIDTH(16)) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic push(input logic signed [31:0] res, input logic sat);
    exp_t e;
    e.res = res;
    e.sat = sat;
    exp_q.push_back(e);
  endtask

  task automatic step(input logic av, input logic signed [15:0] a, input logic bv,
                      input logic signed [15:0] b, input logic [15:0] k, input logic rdy);
    bus.i_a_vld   = av;
    bus.i_a       = a;
    bus.i_b_vld   = bv;
    bus.i_b       = b;
    bus.i_k_len   = k;
    bus.i_res_rdy = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic pair(input int a, input int b, input int k, input logic rdy);
    step(1'b1, 16'(a), 1'b1, 16'(b), 16'(k), rdy);
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, 16'sh0055, 1'b0, -16'sd3, 16'd7, rdy);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(1'b0);
    rst = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_res_vld"}, 64'(bus.o_res_vld), 64'd0);
    chk({tag, "_res"},     64'(bus.o_res),     64'd0);
    chk({tag, "_busy"},    64'(bus.o_busy),    64'd0);
    chk({tag, "_ovf"},     64'(bus.o_ovf),     64'd0);
    chk({tag, "_err"},     64'(bus.o_err),     64'd0);
    chk({tag, "_fwd"},     64'({bus.o_a_vld, bus.o_a, bus.o_b_vld, bus.o_b}), 64'd0);
  endtask

  // Monitor: result transfers against the scoreboard, plus one-cycle operand forwarding.
  initial begin
    logic        have_prev;
    logic        prev_rst;
    logic [33:0] prev_in;
    exp_t        e;
    have_prev = 1'b0;
    prev_rst  = 1'b1;
    prev_in   = '0;
    forever begin
      @(negedge clk);
      if (have_prev && !prev_rst) begin
        chk("fwd", 64'({bus.o_a_vld, bus.o_a, bus.o_b_vld, bus.o_b}), 64'(prev_in));
      end
      if (!rst && bus.o_res_vld && bus.i_res_rdy) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", 64'(bus.o_res), 64'hdead);
        end else begin
          e = exp_q.pop_front();
          chk("res", 64'($signed(bus.o_res)), 64'(e.res));
`ifdef SA_PE_SAT_EN
          chk("sat", 64'(bus.o_sat), 64'(e.sat));
`endif
        end
      end
      prev_in   = {bus.i_a_vld, bus.i_a, bus.i_b_vld, bus.i_b};
      prev_rst  = rst;
      have_prev = 1'b1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    idle(1'b0);
    idle(1'b0);
    chk_all_zero("reset");
    rst = 1'b0;

    // 4-term dot product: 2 + 12 - 30 - 56 = -72
    push(-32'sd72, 1'b0);
    pair(1, 2, 4, 1'b1);   chk("dot_busy1", 64'(bus.o_busy), 64'd1);
    pair(3, 4, 4, 1'b1);   chk("dot_busy2", 64'(bus.o_busy), 64'd1);
    pair(-5, 6, 4, 1'b1);  chk("dot_busy3", 64'(bus.o_busy), 64'd1);
    pair(7, -8, 4, 1'b1);  chk("dot_busy4", 64'(bus.o_busy), 64'd0);
    chk("dot_vld", 64'(bus.o_res_vld), 64'd1);
    idle(1'b1);            chk("dot_vld_drop", 64'(bus.o_res_vld), 64'd0);

    // Backpressure: 6 is overwritten by 20 while stalled
    pair(2, 3, 1, 1'b0);
    chk("bp_res6", 64'($signed(bus.o_res)), 64'd6);
    chk("bp_ovf0", 64'(bus.o_ovf), 64'd0);
    push(32'sd20, 1'b0);
    pair(4, 5, 1, 1'b0);
    chk("bp_vld", 64'(bus.o_res_vld), 64'd1);
    chk("bp_ovf1", 64'(bus.o_ovf), 64'd1);
    idle(1'b1);
    idle(1'b1);            chk("bp_vld_drop", 64'(bus.o_res_vld), 64'd0);
    chk("bp_ovf_sticky", 64'(bus.o_ovf), 64'd1);

    // Same, but the old result drains in the completion cycle
    do_reset();
    push(32'sd6, 1'b0);
    pair(2, 3, 1, 1'b0);
    push(32'sd20, 1'b0);
    pair(4, 5, 1, 1'b1);
    chk("bp2_vld", 64'(bus.o_res_vld), 64'd1);
    chk("bp2_ovf0", 64'(bus.o_ovf), 64'd0);
    idle(1'b1);
    idle(1'b1);            chk("bp2_vld_drop", 64'(bus.o_res_vld), 64'd0);

    // Gaps and a half-valid cycle: 1 + 4 + 9 = 14
    push(32'sd14, 1'b0);
    pair(1, 1, 3, 1'b1);
    for (int i = 0; i < 5; i++) begin
      idle(1'b1);
      chk("gap_busy", 64'(bus.o_busy), 64'd1);
    end
    pair(2, 2, 3, 1'b1);
    step(1'b1, 16'sd9, 1'b0, 16'sd0, 16'd3, 1'b1);
    chk("err_set", 64'(bus.o_err), 64'd1);
    chk("err_busy", 64'(bus.o_busy), 64'd1);
    pair(3, 3, 3, 1'b1);
    chk("gap_done_busy", 64'(bus.o_busy), 64'd0);
    idle(1'b1);

    // k_len 0 acts as 1; k_len is only sampled at tile start
    push(-32'sd21, 1'b0);
    pair(-7, 3, 0, 1'b1);  chk("k0_busy", 64'(bus.o_busy), 64'd0);
    push(32'sd2, 1'b0);
    pair(1, 1, 2, 1'b1);
    pair(1, 1, 9, 1'b1);   chk("kchg_busy", 64'(bus.o_busy), 64'd0);
    idle(1'b1);

    // Reset mid-tile discards partial sum and sticky flags
    pair(5, 5, 4, 1'b1);
    pair(6, 6, 4, 1'b1);
    do_reset();
    chk_all_zero("midrst");
    push(32'sd4, 1'b0);
    for (int i = 0; i < 4; i++) pair(1, 1, 4, 1'b1);
    idle(1'b1);

    // 3 x 2^30 overflows a 32-bit accumulator
`ifdef SA_PE_SAT_EN
    push(32'sh7fffffff, 1'b1);
`else
    push(-32'sd1073741824, 1'b0);
`endif
    for (int i = 0; i < 3; i++) pair(-32768, -32768, 3, 1'b1);
    idle(1'b1);

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) idle(1'b1);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
